// File: rtl/button_select_conditioner.sv
// Push-button conditioning stage.
// Each active-low, pulled-up button pin is brought into the CLK domain by a
// two-flop synchroniser. It is then debounced by its own stability counter.
// The stage drives a clean active-high level, one-cycle press and release
// pulses, and a wrapping select code. The select code goes straight to the
// select input of the downstream decoder/mux/demux stage.
// Buttons 0 and 1 step the select code up and down. Any further buttons are
// only conditioned.
module button_select_conditioner #(
    parameter int N_BTN     = 2,     // number of buttons, at least 2
    parameter int DB_CYCLES = 16000, // stable cycles needed to accept a change, at least 2
    parameter int CNT_W     = 14,    // debounce counter width, 2**CNT_W >= DB_CYCLES
    parameter int SEL_W     = 2      // select code width
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [SEL_W-1:0] sel
);

    // The counter value on which a pending change is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] sync_s1_q;
    logic [N_BTN-1:0] sync_s2_q;
    logic [N_BTN-1:0] raw;

    logic [N_BTN-1:0] level_q,   level_d;
    logic [N_BTN-1:0] press_q,   press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];

    logic [SEL_W-1:0] sel_q, sel_d;
    logic             step_up;
    logic             step_dn;

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    // Two-flop chain per pin. Reset loads 1 because a released button reads
    // high through its pull-up.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // values from before the edge. Blocking here would collapse s1 and s2 into
    // a single flop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_s1_q <= '1;
            sync_s2_q <= '1;
        end else begin
            sync_s1_q <= btn_n;
            sync_s2_q <= sync_s1_q;
        end
    end

    // The pins are active-low. Invert once here so the rest of the logic sees
    // 1 = pressed.
    assign raw = ~sync_s2_q;

    // ------------------------------------------------------------------
    // Debounce
    // ------------------------------------------------------------------
    // Per-button stability counter.
    // - It counts consecutive cycles where the synchronised input disagrees
    //   with the accepted level.
    // - A single agreeing cycle restarts it.
    // - On the DB_CYCLES-th disagreeing cycle the new level is taken and the
    //   matching pulse fires for that one cycle.
    // NOTE: every signal driven here gets a default first. Otherwise a branch
    // that does not write it would infer a latch.
    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        cnt_d     = cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (raw[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_LAST) begin
                level_d[i]   = raw[i];
                press_d[i]   = raw[i];
                release_d[i] = ~raw[i];
                cnt_d[i]     = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Debounce registers. Reset drops any partial count and any in-flight
    // pulse, so a button that is still held must qualify again from scratch.
    // NOTE: the counter array is reset element by element. Unlike a data RAM,
    // its contents are control state that must start from a known value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Select stepper
    // ------------------------------------------------------------------
    // The stepper is driven from the registered press pulses, so sel moves one
    // edge after the pulse.
    // A simultaneous up and down press cancels out. The code wraps in both
    // directions through its natural width.
    assign step_up = press_q[0] & ~press_q[1];
    assign step_dn = press_q[1] & ~press_q[0];

    // Next select code.
    always_comb begin
        sel_d = sel_q;
        if (step_up) begin
            sel_d = sel_q + SEL_W'(1);
        end else if (step_dn) begin
            sel_d = sel_q - SEL_W'(1);
        end
    end

    // Select register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q <= '0;
        end else begin
            sel_q <= sel_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign sel         = sel_q;

endmodule

// File: doc/button_select_conditioner.md
Name: button_select_conditioner

Overview:
Conditioning stage for the active-low, pull-up push-buttons on the board pins.
- Synchronises each button to CLK, debounces it with a per-button stability counter, and emits a clean level, one-cycle press/release pulses and a wrapping select code.
- The select code feeds the select input of the downstream 2-to-4 decoder / 4-to-1 mux / 1-to-4 demux stage directly, with no inversion needed there.

Parameters:
N_BTN, 2, number of button inputs (>=2; buttons 0 and 1 drive the select stepper).
DB_CYCLES, 16000, consecutive stable cycles required to accept a change (1 ms at 16 MHz); must be >=2.
CNT_W, 14, debounce counter width; must satisfy 2^CNT_W >= DB_CYCLES.
SEL_W, 2, width of the select code.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous active-high reset.
btn_n  input  N_BTN  raw button pins, active-low (0 = pressed), asynchronous to CLK.
btn_level  output  N_BTN  debounced state, active-high (1 = pressed).
btn_press  output  N_BTN  one-cycle pulse when btn_level goes 0->1.
btn_release  output  N_BTN  one-cycle pulse when btn_level goes 1->0.
sel  output  SEL_W  select code for the downstream decoder/mux.

Behaviour:
- One clock (CLK); reset is synchronous and active-high (RST); no asynchronous reset anywhere.
- Reset values:
  - Synchroniser flops = 1 (idle/released).
  - btn_level, btn_press, btn_release = 0.
  - Debounce counters = 0.
  - sel = 0.
- Synchroniser, per button: two-flop chain s1 <= btn_n, s2 <= s1. The logic uses raw = ~s2, so 1 = pressed.
- Debounce, per button, independent:
  - If raw == btn_level: counter <= 0.
  - If raw != btn_level and counter < DB_CYCLES-1: counter <= counter+1.
  - If raw != btn_level and counter == DB_CYCLES-1: btn_level <= raw, counter <= 0, and the matching pulse is set for exactly that cycle.
  - A single cycle with raw == btn_level clears the counter; glitches shorter than DB_CYCLES cycles never reach btn_level.
- Latency: number the first rising edge that samples the new pin value as edge 1.
  - btn_level and the pulse update on edge DB_CYCLES+2.
  - The pulse is high for exactly one cycle; btn_press and btn_release are never both high for the same button.
  - The minimum spacing between two level changes of one button is DB_CYCLES cycles.
- Select stepper, registered from the pulse outputs:
  - btn_press[0] alone: sel <= sel+1, modulo 2^SEL_W.
  - btn_press[1] alone: sel <= sel-1, modulo 2^SEL_W.
  - Both in the same cycle, or neither: sel holds.
  - sel changes on edge DB_CYCLES+3, one edge after the press pulse.
  - Buttons 2..N_BTN-1 do not affect sel.
- Wrap-around: sel = 2^SEL_W-1 plus an up-press gives 0; sel = 0 plus a down-press gives 2^SEL_W-1.
- Reset mid-operation: RST high on any edge forces every reset value on that edge, discarding partial counts and in-flight pulses. After RST falls, a button still held must re-qualify through the full DB_CYCLES+2 latency before btn_level rises.
- Holding a button produces only one press pulse; release needs its own full debounce.

Test Plan:
1. RST for 3 cycles, btn_n = all 1 -> btn_level=0, pulses=0, sel=0 on the first edge with RST high and after it.
2. DB_CYCLES=4. Drive btn_n[0]=0 and hold -> btn_level[0] and btn_press[0] rise after edge 6; btn_press[0] high exactly 1 cycle; sel=1 after edge 7.
3. DB_CYCLES=4. btn_n[0] low for 3 cycles, high for 1, then low for 2, then high -> btn_level[0] stays 0, no pulses, sel stays 0.
4. Start from sel=3 (three up-presses), then one more press on button 0 -> sel=0. Then one press on button 1 -> sel=3. Each press is followed by release after more than DB_CYCLES cycles, and each release gives a single btn_release pulse.
5. Press buttons 0 and 1 on the same cycle, held -> btn_press=2'b11 for one cycle, sel unchanged.
6. Hold button 0 down and assert RST at counter value 2 (DB_CYCLES=4) -> all outputs 0 on that edge. After RST drops with the button still held, btn_level[0] rises exactly DB_CYCLES+2 edges later.
